wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges the MEM/WB pipeline write and the
// multi-cycle MDU result onto the single register-file write port.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_out,
    output logic [7:0]  drop_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;

    logic        p, m;
    logic        g_we, ld, drop, stall_d;
    logic [4:0]  g_addr;
    logic [31:0] g_data;

    assign mdu_ready = (state == IDLE);
    assign p = wb_we && (wb_addr != 5'd0);
    assign m = mdu_valid && mdu_ready && (mdu_addr != 5'd0);

    // Next-state, grant selection and buffer/counter updates.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        g_we    = 1'b0;
        g_addr  = wb_addr;
        g_data  = wb_data;
        ld      = 1'b0;
        drop    = 1'b0;
        stall_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (p) begin
                    g_we = 1'b1;
                    if (m) begin
                        if (wb_addr == mdu_addr) begin
                            drop = 1'b1;
                        end else begin
                            ld      = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = PEND;
                        end
                    end
                end else if (m) begin
                    g_we   = 1'b1;
                    g_addr = mdu_addr;
                    g_data = mdu_data;
                end
            end
            PEND: begin
                g_we = 1'b1;
                if (!p) begin
                    g_addr  = pend_addr;
                    g_data  = pend_data;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (wb_addr == pend_addr) begin
                    drop    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 4'd1;
                    if (cnt_d == LIMIT) begin
                        state_d = FORCE;
                        stall_d = 1'b1;
                    end
                end
            end
            FORCE: begin
                g_we    = 1'b1;
                g_addr  = pend_addr;
                g_data  = pend_data;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending buffer, write port and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend_addr <= 5'd0;
            pend_data <= 32'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            stall_out <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            stall_out <= stall_d;
            rf_we     <= g_we;
            if (g_we) begin
                rf_waddr <= g_addr;
                rf_wdata <= g_data;
            end
            if (ld) begin
                pend_addr <= mdu_addr;
                pend_data <= mdu_data;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a per-cycle expected-write
// scoreboard; STARVE_LIMIT left at its default of 4.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_out;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];

    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_out(stall_out), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic mv,
                       input logic [4:0] ma, input logic [31:0] md);
        wb_we     = we;
        wb_addr   = a;
        wb_data   = d;
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
    endtask

    // Push the write expected from this edge, clock it, pop and compare.
    task automatic cyc(input string tag, input logic we,
                       input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        q.push_back('{we: we, a: a, d: d});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".we"}, 32'(rf_we), 32'(e.we));
        if (e.we) begin
            chk({tag, ".addr"}, 32'(rf_waddr), 32'(e.a));
            chk({tag, ".data"}, rf_wdata, e.d);
        end
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.we", 32'(rf_we), 0);
        chk("rst.addr", 32'(rf_waddr), 0);
        chk("rst.data", rf_wdata, 0);
        chk("rst.stall", 32'(stall_out), 0);
        chk("rst.drop", 32'(drop_cnt), 0);
        chk("rst.ready", 32'(mdu_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Pipeline-only write
        drv(1, 5, 32'hAAAA0000, 0, 0, 0);
        cyc("p_only", 1, 5, 32'hAAAA0000);
        chk("p_only.stall", 32'(stall_out), 0);
        chk("p_only.ready", 32'(mdu_ready), 1);

        // Collision: pipeline first, MDU buffered one cycle
        drv(1, 3, 32'h33, 1, 7, 32'h12345678);
        cyc("coll1", 1, 3, 32'h33);
        chk("coll1.ready", 32'(mdu_ready), 0);
        drv(0, 0, 0, 0, 0, 0);
        cyc("coll2", 1, 7, 32'h12345678);
        chk("coll2.ready", 32'(mdu_ready), 1);

        // MDU-only write
        drv(0, 0, 0, 1, 10, 32'hD00D);
        cyc("m_only", 1, 10, 32'hD00D);

        // Starvation: four pipeline wins then forced MDU drain
        drv(1, 2, 32'h22, 1, 7, 32'h77);
        cyc("starve0", 1, 2, 32'h22);
        for (int i = 1; i <= 4; i++) begin
            drv(1, 5'(i), 32'(i * 16), 1, 11, 32'hBAD);
            cyc("starve", 1, 5'(i), 32'(i * 16));
            chk("starve.stall", 32'(stall_out), (i == 4) ? 1 : 0);
            chk("starve.ready", 32'(mdu_ready), 0);
        end
        drv(1, 5, 32'h55, 0, 0, 0);
        cyc("force", 1, 7, 32'h77);
        chk("force.stall", 32'(stall_out), 0);
        chk("force.ready", 32'(mdu_ready), 1);
        cyc("represent", 1, 5, 32'h55);

        // WAW override of a pending entry
        drv(1, 1, 32'h11, 1, 9, 32'h99);
        cyc("waw0", 1, 1, 32'h11);
        drv(1, 9, 32'h9999, 0, 0, 0);
        cyc("waw1", 1, 9, 32'h9999);
        chk("waw.drop", 32'(drop_cnt), 1);
        chk("waw.ready", 32'(mdu_ready), 1);
        drv(0, 0, 0, 0, 0, 0);
        cyc("waw.idle", 0, 0, 0);
        chk("hold.addr", 32'(rf_waddr), 9);
        chk("hold.data", rf_wdata, 32'h9999);

        // r0 on both sides: nothing written, nothing dropped
        drv(1, 0, 32'hF0, 1, 0, 32'hF1);
        cyc("zero", 0, 0, 0);
        chk("zero.drop", 32'(drop_cnt), 1);
        chk("zero.ready", 32'(mdu_ready), 1);

        // r0 pipeline with real MDU target: MDU goes straight through
        drv(1, 0, 32'hF0, 1, 6, 32'h66);
        cyc("zero_p", 1, 6, 32'h66);

        // Same-address collision in IDLE; drive drop counter to saturation
        for (int i = 0; i < 299; i++) begin
            drv(1, 4, 32'(i), 1, 4, 32'hDEAD);
            cyc("sat", 1, 4, 32'(i));
        end
        chk("sat.drop", 32'(drop_cnt), 255);
        chk("sat.ready", 32'(mdu_ready), 1);

        // Reset while an entry is pending
        drv(1, 2, 32'h2, 1, 8, 32'h88);
        cyc("rpend", 1, 2, 32'h2);
        chk("rpend.ready", 32'(mdu_ready), 0);
        drv(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rmid.we", 32'(rf_we), 0);
        chk("rmid.addr", 32'(rf_waddr), 0);
        chk("rmid.data", rf_wdata, 0);
        chk("rmid.drop", 32'(drop_cnt), 0);
        chk("rmid.stall", 32'(stall_out), 0);
        chk("rmid.ready", 32'(mdu_ready), 1);
        #2;
        rst = 1'b0;
        cyc("rpost1", 0, 0, 0);
        cyc("rpost2", 0, 0, 0);
        chk("rpost.data", rf_wdata, 0);

        chk("sb.empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
